// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter: round-robin owner selection for the shared memory port.
// One grant at a time, one dead cycle between owners so the memory mux can
// settle, and the client that just released drops to lowest priority.
// Optional feature macro: MEM_ARB_HOLD_TIMEOUT_EN. When it is defined, a grant
// held for HOLD_MAX cycles is revoked with a one-cycle timeout pulse. The
// revoked client is then skipped until its request is seen low once.
// HOLD_MAX must be at least 2 when the feature is enabled.
module mem_rr_arbiter #(
  parameter int CLIENTS  = 4,
  parameter int HOLD_MAX = 256
) (
  input  logic                       clk,
  input  logic                       nRst,
  input  logic [CLIENTS-1:0]         request,
  output logic [CLIENTS-1:0]         grant,
  output logic                       busy,
  output logic [$clog2(CLIENTS)-1:0] owner,
  output logic                       timeout
);

  localparam int OW = $clog2(CLIENTS);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t             state_reg, state_next;
  logic [CLIENTS-1:0] grant_reg, grant_next;
  logic               busy_reg, busy_next;
  logic [OW-1:0]      owner_reg, owner_next;
  logic [OW-1:0]      ptr_reg, ptr_next;

  logic [CLIENTS-1:0] masked;
  logic [CLIENTS-1:0] eligible;
  logic [CLIENTS-1:0] owner_onehot;
  logic               owner_req;
  logic               win_valid;
  logic [OW-1:0]      win_idx;
  logic [OW-1:0]      owner_inc;

`ifdef MEM_ARB_HOLD_TIMEOUT_EN
  localparam int CW = $clog2(HOLD_MAX);

  logic [CW-1:0]      hold_cnt_reg, hold_cnt_next;
  logic [CLIENTS-1:0] mask_reg, mask_next;
  logic               timeout_reg, timeout_next;
  logic               hold_expired;

  assign hold_expired = (hold_cnt_reg == CW'(HOLD_MAX - 1));
  assign masked       = mask_reg;
  assign timeout      = timeout_reg;
`else
  assign masked       = '0;
  assign timeout      = 1'b0;
`endif

  // Per-client decode: eligibility for arbitration and owner match.
  genvar gi;
  generate
    for (gi = 0; gi < CLIENTS; gi++) begin : g_client
      assign eligible[gi]     = request[gi] & ~masked[gi];
      assign owner_onehot[gi] = (owner_reg == OW'(gi));
    end
  endgenerate

  assign owner_req = |(request & owner_onehot);
  assign owner_inc = (owner_reg == OW'(CLIENTS - 1)) ? '0 : owner_reg + OW'(1);

  // Rotating scan from ptr. The loop runs backwards so that the eligible
  // client nearest to ptr is the last one written and therefore wins.
  always_comb begin : scan
    logic [OW:0] pos;
    win_valid = 1'b0;
    win_idx   = ptr_reg;
    pos       = '0;
    for (int k = CLIENTS - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_reg} + (OW+1)'(k);
      if (pos >= (OW+1)'(CLIENTS)) begin
        pos = pos - (OW+1)'(CLIENTS);
      end
      if (eligible[pos[OW-1:0]]) begin
        win_valid = 1'b1;
        win_idx   = pos[OW-1:0];
      end
    end
  end

  // Next-state and registered-output logic for IDLE / GRANT / RELEASE.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    busy_next  = busy_reg;
    owner_next = owner_reg;
    ptr_next   = ptr_reg;
`ifdef MEM_ARB_HOLD_TIMEOUT_EN
    hold_cnt_next = hold_cnt_reg;
    timeout_next  = 1'b0;
    // A mask bit survives only while that client keeps requesting.
    mask_next     = mask_reg & request;
`endif
    case (state_reg)
      IDLE, RELEASE: begin
        if (win_valid) begin
          state_next = GRANT;
          grant_next = CLIENTS'(1) << win_idx;
          busy_next  = 1'b1;
          owner_next = win_idx;
`ifdef MEM_ARB_HOLD_TIMEOUT_EN
          hold_cnt_next = '0;
`endif
        end else begin
          state_next = IDLE;
          grant_next = '0;
          busy_next  = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_next = RELEASE;
          grant_next = '0;
          busy_next  = 1'b0;
          ptr_next   = owner_inc;
        end
`ifdef MEM_ARB_HOLD_TIMEOUT_EN
        else if (hold_expired) begin
          state_next   = RELEASE;
          grant_next   = '0;
          busy_next    = 1'b0;
          ptr_next     = owner_inc;
          timeout_next = 1'b1;
          mask_next    = (mask_reg & request) | owner_onehot;
        end else begin
          hold_cnt_next = hold_cnt_reg + CW'(1);
        end
`endif
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset clears grant without waiting for a clock.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      busy_reg  <= 1'b0;
      owner_reg <= '0;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      busy_reg  <= busy_next;
      owner_reg <= owner_next;
      ptr_reg   <= ptr_next;
    end
  end

`ifdef MEM_ARB_HOLD_TIMEOUT_EN
  // Hold counter, revoke mask and timeout pulse registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      hold_cnt_reg <= '0;
      mask_reg     <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      hold_cnt_reg <= hold_cnt_next;
      mask_reg     <= mask_next;
      timeout_reg  <= timeout_next;
    end
  end
`endif

  assign grant = grant_reg;
  assign busy  = busy_reg;
  assign owner = owner_reg;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Testbench for mem_rr_arbiter: scenario tasks with a scoreboard of expected
// grantees, plus a negedge monitor for the always-true grant properties.
module tb_mem_rr_arbiter;
  localparam int CLIENTS  = 4;
  localparam int HOLD_MAX = 8;

  logic         clk = 1'b0;
  logic         nRst = 1'b1;
  logic [3:0]   request = 4'b0000;
  logic [3:0]   grant;
  logic         busy;
  logic [1:0]   owner;
  logic         timeout;

  int           checks = 0;
  int           failures = 0;
  int           exp_q[$];
  logic [15:0]  mem [0:15];
  logic [3:0]   req_at_edge = 4'b0000;
  logic [3:0]   prev_grant = 4'b0000;
  bit           mon_en = 1'b0;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.CLIENTS(CLIENTS), .HOLD_MAX(HOLD_MAX)) dut (
    .clk     (clk),
    .nRst    (nRst),
    .request (request),
    .grant   (grant),
    .busy    (busy),
    .owner   (owner),
    .timeout (timeout)
  );

  always @(posedge clk) req_at_edge <= request;

  // Properties that hold on every cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((grant & (grant - 4'd1)) !== 4'd0) begin
        failures++;
        $display("FAIL mon_onehot grant=%b required one-hot or zero", grant);
      end
      checks++;
      if (busy !== (|grant)) begin
        failures++;
        $display("FAIL mon_busy busy=%b required %b (grant=%b)", busy, |grant, grant);
      end
      checks++;
      if ((grant & ~req_at_edge) !== 4'd0) begin
        failures++;
        $display("FAIL mon_subset grant=%b required subset of sampled request=%b", grant, req_at_edge);
      end
      checks++;
      if (grant !== 4'd0 && prev_grant !== 4'd0 && grant !== prev_grant) begin
        failures++;
        $display("FAIL mon_handover grant=%b prev=%b required an idle cycle between owners", grant, prev_grant);
      end
`ifndef MEM_ARB_HOLD_TIMEOUT_EN
      checks++;
      if (timeout !== 1'b0) begin
        failures++;
        $display("FAIL mon_timeout_tied timeout=%b required 0", timeout);
      end
`endif
    end
    prev_grant = grant;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    nRst = 1'b0;
    request = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
  endtask

  // Waits up to budget negedges for a grant; idx=-1 if none appears.
  task automatic wait_grant(input int budget, output int idx, output int idle);
    idx = -1;
    idle = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (grant !== 4'd0) begin
        for (int i = 0; i < CLIENTS; i++) if (grant[i]) idx = i;
        return;
      end
      idle++;
    end
  endtask

  task automatic test_reset();
    #1 nRst = 1'b0;
    #1;
    checks++; if (grant !== 4'd0) begin failures++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL reset_owner got=%0d exp=0", owner); end
    checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL reset_timeout got=%b exp=0", timeout); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
    mon_en = 1'b1;
    @(negedge clk);
    checks++; if (grant !== 4'd0) begin failures++; $display("FAIL reset_idle got=%b exp=0000", grant); end
    $display("test_reset done");
  endtask

  task automatic test_single();
    int idx, idle, exp;
    apply_reset();
    exp_q.push_back(0);
    @(posedge clk); #1 request = 4'b0001;
    @(negedge clk);
    checks++; if (grant !== 4'd0) begin failures++; $display("FAIL single_early got=%b exp=0000", grant); end
    wait_grant(4, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL single_winner got=%0d exp=%0d", idx, exp); end
    checks++; if (idle !== 0) begin failures++; $display("FAIL single_latency got=%0d exp=0 extra cycles", idle); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL single_owner got=%0d exp=0", owner); end
    @(posedge clk); #1 request = 4'b0000;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL single_hold got=%b exp=0001", grant); end
    @(negedge clk);
    checks++; if (grant !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL single_release got=%b/%b exp=0000/0", grant, busy); end
    checks++; if (owner !== 2'd0) begin failures++; $display("FAIL single_owner_kept got=%0d exp=0", owner); end
    @(negedge clk);
    checks++; if (grant !== 4'd0) begin failures++; $display("FAIL single_idle got=%b exp=0000", grant); end
    $display("test_single done");
  endtask

  task automatic test_two_clients();
    int idx, idle, exp;
    logic [15:0] rd;
    logic [3:0] exp_g;
    apply_reset();
    mem[2] = 16'h0000;
    exp_q.push_back(0);
    exp_q.push_back(1);
    @(posedge clk); #1 request = 4'b0011;
    wait_grant(4, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL two_first got=%0d exp=%0d", idx, exp); end
    if (grant[0]) mem[2] = 16'hABCD;
    @(posedge clk); #1 request[0] = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 4'b0001) begin failures++; $display("FAIL two_hold got=%b exp=0001", grant); end
    @(negedge clk);
    checks++; if (grant !== 4'b0000) begin failures++; $display("FAIL two_dead got=%b exp=0000", grant); end
    @(negedge clk);
    exp = exp_q.pop_front();
    exp_g = 4'b0001 << exp;
    checks++; if (grant !== exp_g) begin failures++; $display("FAIL two_second got=%b exp=%b", grant, exp_g); end
    rd = grant[1] ? mem[2] : 16'h0000;
    checks++; if (rd !== 16'hABCD) begin failures++; $display("FAIL two_read got=%h exp=abcd", rd); end
    @(posedge clk); #1 request = 4'b0000;
    repeat (3) @(negedge clk);
    $display("test_two_clients done");
  endtask

  task automatic test_round_robin();
    int idx, idle, exp;
    apply_reset();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    @(posedge clk); #1 request = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_grant(12, idx, idle);
      exp = exp_q.pop_front();
      checks++; if (idx !== exp) begin failures++; $display("FAIL rr_order[%0d] got=%0d exp=%0d", n, idx, exp); end
      if (n > 0) begin
        checks++; if (idle !== 1) begin failures++; $display("FAIL rr_gap[%0d] got=%0d exp=1 idle cycles", n, idle); end
      end
      if (idx < 0) break;
      @(posedge clk); @(posedge clk); #1 request[idx] = 1'b0;
      @(negedge clk);
      checks++; if (grant[idx] !== 1'b1) begin failures++; $display("FAIL rr_hold[%0d] got=%b exp bit %0d set", n, grant, idx); end
      @(posedge clk); #1 request[idx] = 1'b1;
      $display("rr grant %0d: client=%0d idle=%0d", n, idx, idle);
    end
    @(posedge clk); #1 request = 4'b0000;
    repeat (4) @(negedge clk);
    checks++; if (grant !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL rr_drain got=%b/%b exp=0000/0", grant, busy); end
    $display("test_round_robin done");
  endtask

  task automatic test_reset_mid_grant();
    int idx, idle, exp;
    apply_reset();
    exp_q.push_back(2);
    exp_q.push_back(2);
    exp_q.push_back(2);
    @(posedge clk); #1 request = 4'b0100;
    wait_grant(4, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL rst_first got=%0d exp=%0d", idx, exp); end
    @(posedge clk); #1 request = 4'b0000;
    repeat (2) @(posedge clk);
    #1 request = 4'b0100;
    wait_grant(6, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL rst_second got=%0d exp=%0d", idx, exp); end
    @(posedge clk); #1 request = 4'b1100;
    @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    checks++; if (grant !== 4'd0) begin failures++; $display("FAIL rst_async_grant got=%b exp=0000", grant); end
    checks++; if (busy !== 1'b0 || owner !== 2'd0) begin failures++; $display("FAIL rst_async_state busy=%b owner=%0d exp=0/0", busy, owner); end
    @(posedge clk);
    @(negedge clk);
    nRst = 1'b1;
    wait_grant(4, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL rst_ptr_restart got=%0d exp=%0d", idx, exp); end
    checks++; if (idle !== 0 || owner !== 2'd2) begin failures++; $display("FAIL rst_regrant idle=%0d owner=%0d exp=0/2", idle, owner); end
    @(posedge clk); #1 request = 4'b0000;
    repeat (3) @(negedge clk);
    $display("test_reset_mid_grant done");
  endtask

  task automatic test_withdrawn();
    int idx, idle, exp, seen3;
    apply_reset();
    exp_q.push_back(1);
    @(posedge clk); #1 request = 4'b0010;
    wait_grant(4, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL wd_first got=%0d exp=%0d", idx, exp); end
    seen3 = 0;
    @(posedge clk); #1 request = 4'b1010;
    repeat (2) @(posedge clk);
    #1 request = 4'b0010;
    @(posedge clk); #1 request = 4'b0000;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (grant[3]) seen3++;
    end
    checks++; if (seen3 !== 0) begin failures++; $display("FAIL wd_never_granted got=%0d exp=0 cycles of grant[3]", seen3); end
    checks++; if (grant !== 4'd0 || busy !== 1'b0) begin failures++; $display("FAIL wd_idle got=%b/%b exp=0000/0", grant, busy); end
    checks++; if (owner !== 2'd1) begin failures++; $display("FAIL wd_owner_kept got=%0d exp=1", owner); end
    $display("test_withdrawn done");
  endtask

`ifdef MEM_ARB_HOLD_TIMEOUT_EN
  task automatic test_hold_timeout();
    int idx, idle, exp, hold, blocked;
    apply_reset();
    exp_q.push_back(0);
    exp_q.push_back(0);
    @(posedge clk); #1 request = 4'b0011;
    wait_grant(4, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL to_first got=%0d exp=%0d", idx, exp); end
    hold = 1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (grant === 4'b0001) hold++;
      else break;
    end
    checks++; if (hold !== HOLD_MAX) begin failures++; $display("FAIL to_hold_len got=%0d exp=%0d", hold, HOLD_MAX); end
    checks++; if (grant !== 4'd0 || timeout !== 1'b1) begin failures++; $display("FAIL to_pulse grant=%b timeout=%b exp=0000/1", grant, timeout); end
    @(negedge clk);
    checks++; if (grant !== 4'b0010 || timeout !== 1'b0) begin failures++; $display("FAIL to_next grant=%b timeout=%b exp=0010/0", grant, timeout); end
    @(posedge clk); #1 request = 4'b0001;
    blocked = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (grant[0]) blocked++;
    end
    checks++; if (blocked !== 0) begin failures++; $display("FAIL to_masked got=%0d exp=0 cycles of grant[0]", blocked); end
    @(posedge clk); #1 request = 4'b0000;
    @(posedge clk); #1 request = 4'b0001;
    wait_grant(4, idx, idle);
    exp = exp_q.pop_front();
    checks++; if (idx !== exp) begin failures++; $display("FAIL to_unmasked got=%0d exp=%0d", idx, exp); end
    @(posedge clk); #1 request = 4'b0000;
    repeat (3) @(negedge clk);
    $display("test_hold_timeout done");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_two_clients();
    test_round_robin();
    test_reset_mid_grant();
    test_withdrawn();
`ifdef MEM_ARB_HOLD_TIMEOUT_EN
    test_hold_timeout();
`endif
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
